mem_access_unit: RTL

Memory-stage load/store controller that sits directly upstream of the byte-addressed data SRAM. It accepts one load or store request at a time from the pipeline's MEM stage over a valid/ready handshake, and drives the SRAM port (4-bit byte write enable, 16-bit byte address, 32-bit write data, combinational 32-bit read data). It sign- or zero-extends load data and returns the result over a second valid/ready handshake. Misaligned and illegal-width accesses are trapped rather than performed.

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_load_extend.sv | 18 +
 rtl/mem_access_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared funct3 codes, FSM states and byte-enable helpers
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic [3:0] be_of(input logic [2:0] f3);
        return f3 == F3_SB ? BE_B : f3 == F3_SH ? BE_H : BE_W;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: sign/zero-extends raw SRAM read data according to the load width code
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // Byte and half loads extend from the lowest lanes; anything else passes through
    always_comb begin
        data = funct3 == F3_LB  ? {{24{raw[7]}}, raw[7:0]} :
               funct3 == F3_LBU ? {24'd0, raw[7:0]} :
               funct3 == F3_LH  ? {{16{raw[15]}}, raw[15:0]} :
               funct3 == F3_LHU ? {16'd0, raw[15:0]} : raw;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller driving a byte-addressed SRAM
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              rsp_illegal,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state, state_n;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] ext;
    logic              accept, illegal, misaligned;

    assign req_ready  = state == IDLE || (state == RESP && rsp_ready);
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = state == RESP;
    assign illegal    = req_we ? req_funct3 >= 3'd3 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign mem_w_en   = (state == ACCESS && we_q && !rst) ? be_of(f3_q) : 4'b0000;

    load_extend u_ext (
        .funct3 (f3_q),
        .raw    (mem_read_data),
        .data   (ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Faults skip ACCESS; a response handshake may overlap a new acceptance
    always_comb begin
        state_n = state;
        if (state == ACCESS)                 state_n = RESP;
        else if (accept)                     state_n = (illegal || misaligned) ? RESP : ACCESS;
        else if (state == RESP && rsp_ready) state_n = IDLE;
    end

    // Request latch, fault flags and captured load data
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q           <= 1'b0;
            f3_q           <= 3'b000;
            mem_address    <= '0;
            mem_write_data <= '0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
        end else if (accept) begin
            we_q           <= req_we;
            f3_q           <= req_funct3;
            mem_address    <= req_addr;
            mem_write_data <= req_wdata;
            rsp_rdata      <= '0;
            rsp_illegal    <= illegal;
            rsp_misaligned <= !illegal && misaligned;
        end else if (state == ACCESS && !we_q) begin
            rsp_rdata      <= ext;
        end
    end

endmodule
